// File: rtl/lite_job_scheduler_if.sv
// Signal bundle between the job scheduler, its requesters and the shared descriptor engine.
interface lite_job_scheduler_if #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DSC_WIDTH      = 1024,
  parameter int unsigned READREG_NUMBER = 1
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DSC_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [READREG_NUMBER*32-1:0] rsp_data;
  logic                         rsp_timeout;
  logic                         engine_start;
  logic                         engine_ready;
  logic [DSC_WIDTH-1:0]         engine_data;
  logic                         complete_ready;
  logic                         complete_accept;
  logic [READREG_NUMBER*32-1:0] complete_data;
  logic                         busy;
  logic [2:0]                   grant_id;

  // Scheduler side
  modport master (
    input  req_valid, req_data, rsp_ready, engine_ready, complete_ready, complete_data,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, engine_start, engine_data,
           complete_accept, busy, grant_id
  );

  // Requester / engine side
  modport slave (
    output req_valid, req_data, rsp_ready, engine_ready, complete_ready, complete_data,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, engine_start, engine_data,
           complete_accept, busy, grant_id
  );
endinterface

// File: rtl/lite_job_scheduler.sv
// Round-robin scheduler sharing one AXI-Lite descriptor engine among NUM_REQ requesters,
// one job in flight, with optional completion timeout.
module lite_job_scheduler #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DSC_WIDTH      = 1024,
  parameter int unsigned READREG_NUMBER = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lite_job_scheduler_if.master bus
);

  localparam int unsigned RSP_W         = READREG_NUMBER * 32;
  localparam int unsigned CNT_W         = 32;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_ID  = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_grant_id;
  logic [DSC_WIDTH-1:0] r_engine_data;
  logic [CNT_W-1:0]     r_cnt;
  logic [RSP_W-1:0]     r_rsp_data;
  logic                 r_rsp_timeout;

  logic                 w_found;
  logic [2:0]           w_gnt;
  logic [NUM_REQ-1:0]   w_gnt_oh;
  logic [DSC_WIDTH-1:0] w_gnt_data;
  int unsigned          w_dist;
  int unsigned          w_best;
  logic [NUM_REQ-1:0]   w_owner_oh;
  logic                 w_own_ready;
  logic                 w_timeout_hit;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic [NUM_REQ-1:0]   w_rsp_valid;
  logic                 w_engine_start;
  logic                 w_complete_accept;

  // Round-robin pick: smallest rotated distance from the requester after the last grant
  always_comb begin
    w_found    = 1'b0;
    w_gnt      = r_grant_id;
    w_gnt_oh   = '0;
    w_gnt_data = '0;
    w_dist     = 0;
    w_best     = NUM_REQ;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i]) begin
        w_dist = (i + NUM_REQ - 32'(r_grant_id) - 1) % NUM_REQ;
        if (w_dist < w_best) begin
          w_best     = w_dist;
          w_found    = 1'b1;
          w_gnt      = 3'(i);
          w_gnt_oh   = NUM_REQ'(1) << i;
          w_gnt_data = bus.req_data[i*DSC_WIDTH +: DSC_WIDTH];
        end
      end
    end
  end

  // Owner decode for the response handshake; other requesters' rsp_ready is ignored
  always_comb begin
    w_owner_oh  = '0;
    w_own_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == r_grant_id) begin
        w_owner_oh[i] = 1'b1;
        w_own_ready   = bus.rsp_ready[i];
      end
    end
  end

  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_req_ready       = '0;
    w_rsp_valid       = '0;
    w_engine_start    = 1'b0;
    w_complete_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_req_ready = w_gnt_oh;
          w_next      = S_START;
        end
      end
      S_START: begin
        if (bus.engine_ready) begin
          w_engine_start = 1'b1;
          w_next         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.complete_ready) begin
          w_complete_accept = 1'b1;
          w_next            = S_RESP;
        end else if (w_timeout_hit) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = w_owner_oh;
        if (w_own_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Strobes must not be seen by requesters or the engine while reset is applied
    if (!rst_n) begin
      w_req_ready       = '0;
      w_rsp_valid       = '0;
      w_engine_start    = 1'b0;
      w_complete_accept = 1'b0;
    end
  end

  // Descriptor latch, grant history, timeout counter and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant_id    <= LAST_ID;
      r_engine_data <= '0;
      r_cnt         <= '0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant_id    <= w_gnt;
            r_engine_data <= w_gnt_data;
          end
        end
        S_START: begin
          if (bus.engine_ready) begin
            r_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (bus.complete_ready) begin
            r_rsp_data    <= bus.complete_data;
            r_rsp_timeout <= 1'b0;
          end else if (w_timeout_hit) begin
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready       = w_req_ready;
  assign bus.rsp_valid       = w_rsp_valid;
  assign bus.rsp_data        = r_rsp_data;
  assign bus.rsp_timeout     = r_rsp_timeout;
  assign bus.engine_start    = w_engine_start;
  assign bus.engine_data     = r_engine_data;
  assign bus.complete_accept = w_complete_accept;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.grant_id        = r_grant_id;

endmodule

// File: tb/tb_lite_job_scheduler.sv
// Directed bench for lite_job_scheduler: single job, round-robin, back-pressure,
// timeout, completion racing the timeout, and reset mid-job.
module tb_lite_job_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned RR  = 1;
  localparam int unsigned TO  = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [DW-1:0] desc [N];

  lite_job_scheduler_if #(.NUM_REQ(N), .DSC_WIDTH(DW), .READREG_NUMBER(RR)) bus ();

  lite_job_scheduler #(
    .NUM_REQ(N), .DSC_WIDTH(DW), .READREG_NUMBER(RR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    return N'(1) << g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // From IDLE: grant requester g and launch (engine_ready assumed 1); returns in first WAIT cycle
  task automatic launch(input logic [N-1:0] rv, input int g);
    bus.req_valid = rv;
    #1;
    check_eq("req_ready", 64'(bus.req_ready), 64'(oh(g)));
    tick();
    check_eq("req_ready_pulse", 64'(bus.req_ready), 64'(0));
    check_eq("grant_id", 64'(bus.grant_id), 64'(g));
    check_eq("engine_data", 64'(bus.engine_data), 64'(desc[g]));
    check_eq("engine_start", 64'(bus.engine_start), 64'(1));
    tick();
    check_eq("engine_start_off", 64'(bus.engine_start), 64'(0));
  endtask

  task automatic complete_now(input logic [31:0] st, input int g);
    bus.complete_ready = 1'b1;
    bus.complete_data  = st;
    #1;
    check_eq("complete_accept", 64'(bus.complete_accept), 64'(1));
    tick();
    bus.complete_ready = 1'b0;
    #1;
    check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(oh(g)));
    check_eq("rsp_data", 64'(bus.rsp_data), 64'(st));
    check_eq("rsp_timeout", 64'(bus.rsp_timeout), 64'(0));
  endtask

  task automatic release_rsp(input int g);
    bus.rsp_ready = oh(g);
    tick();
    bus.rsp_ready = '0;
    #1;
    check_eq("rsp_valid_drop", 64'(bus.rsp_valid), 64'(0));
    check_eq("busy_idle", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    desc[0] = 64'h0B0B_0B0B_0000_0000;
    desc[1] = 64'hA5A5_A5A5_A5A5_A5A5;
    desc[2] = 64'hC2C2_C2C2_2222_2222;
    desc[3] = 64'hD3D3_D3D3_3333_3333;
    bus.req_valid      = '0;
    bus.req_data       = {desc[3], desc[2], desc[1], desc[0]};
    bus.rsp_ready      = '0;
    bus.engine_ready   = 1'b1;
    bus.complete_ready = 1'b0;
    bus.complete_data  = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_grant_id", 64'(bus.grant_id), 64'(N-1));
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("rst_engine_data", 64'(bus.engine_data), 64'(0));
    check_eq("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'(0));

    // Single requester, completion 10 cycles after engine_start
    launch(4'b0010, 1);
    bus.req_valid = '0;
    for (int c = 0; c < 9; c++) begin
      check_eq("t1_accept_idle", 64'(bus.complete_accept), 64'(0));
      tick();
    end
    complete_now(32'h0000_1234, 1);
    bus.rsp_ready = 4'b0001;
    tick();
    check_eq("t1_foreign_rsp_ready", 64'(bus.rsp_valid), 64'(4'b0010));
    release_rsp(1);

    // Round-robin with all requesters held active
    do_reset();
    for (int k = 0; k < 8; k++) begin
      launch(4'b1111, k % 4);
      complete_now(32'(32'h100 + k), k % 4);
      release_rsp(k % 4);
    end
    launch(4'b1001, 0);
    complete_now(32'h0000_0200, 0);
    release_rsp(0);
    launch(4'b1001, 3);
    complete_now(32'h0000_0300, 3);
    release_rsp(3);

    // Engine back-pressure for 5 cycles after grant
    bus.engine_ready = 1'b0;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    check_eq("t3_grant_id", 64'(bus.grant_id), 64'(2));
    for (int c = 0; c < 5; c++) begin
      check_eq("t3_engine_start_held", 64'(bus.engine_start), 64'(0));
      tick();
    end
    bus.engine_ready = 1'b1;
    #1;
    check_eq("t3_engine_start", 64'(bus.engine_start), 64'(1));
    tick();
    check_eq("t3_engine_start_once", 64'(bus.engine_start), 64'(0));
    complete_now(32'h0000_BEEF, 2);
    release_rsp(2);

    // Timeout after 16 WAIT cycles, late completion ignored
    launch(4'b0001, 0);
    bus.req_valid = '0;
    for (int c = 0; c < 15; c++) tick();
    check_eq("t4_wait_last", 64'(bus.rsp_valid), 64'(0));
    check_eq("t4_busy", 64'(bus.busy), 64'(1));
    tick();
    check_eq("t4_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001));
    check_eq("t4_rsp_timeout", 64'(bus.rsp_timeout), 64'(1));
    check_eq("t4_rsp_data", 64'(bus.rsp_data), 64'(0));
    bus.complete_ready = 1'b1;
    bus.complete_data  = 32'hDEAD_0001;
    #1;
    check_eq("t4_late_accept_resp", 64'(bus.complete_accept), 64'(0));
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = '0;
    #1;
    check_eq("t4_late_accept_idle", 64'(bus.complete_accept), 64'(0));
    check_eq("t4_idle", 64'(bus.busy), 64'(0));
    bus.complete_ready = 1'b0;

    // Completion on the same cycle the timeout would fire
    launch(4'b0010, 1);
    bus.req_valid = '0;
    for (int c = 0; c < 15; c++) tick();
    complete_now(32'h0000_5555, 1);
    release_rsp(1);

    // Reset mid-WAIT; a stale completion afterwards is not accepted
    launch(4'b0100, 2);
    bus.req_valid = '0;
    tick();
    tick();
    do_reset();
    check_eq("t6w_busy", 64'(bus.busy), 64'(0));
    check_eq("t6w_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("t6w_engine_start", 64'(bus.engine_start), 64'(0));
    check_eq("t6w_grant_id", 64'(bus.grant_id), 64'(N-1));
    bus.complete_ready = 1'b1;
    #1;
    check_eq("t6w_stale_accept", 64'(bus.complete_accept), 64'(0));
    bus.complete_ready = 1'b0;

    // Reset mid-RESP, then requester 0 wins first
    launch(4'b1000, 3);
    bus.req_valid = '0;
    complete_now(32'h0000_7777, 3);
    do_reset();
    check_eq("t6r_busy", 64'(bus.busy), 64'(0));
    check_eq("t6r_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("t6r_grant_id", 64'(bus.grant_id), 64'(N-1));
    check_eq("t6r_rsp_data", 64'(bus.rsp_data), 64'(0));
    launch(4'b1001, 0);
    complete_now(32'h0000_0ABC, 0);
    release_rsp(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lite_job_scheduler.md
Name: lite_job_scheduler

Overview:
Shares one AXI-Lite descriptor engine among NUM_REQ job requesters. The engine is the descriptor-to-AXI-Lite adaptor with the engine_start / complete_ready / complete_accept interface.
Sits between per-context job queues and the adaptor. It arbitrates round-robin, launches one descriptor at a time, and waits for completion or timeout. It then returns the read-back status to the owning requester.
Only one job is outstanding at any time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DSC_WIDTH, 1024, descriptor width in bits
READREG_NUMBER, 1, number of 32-bit status words returned per job
TIMEOUT_CYCLES, 65535, maximum cycles in WAIT before the job is abandoned; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester job request, held until req_ready
req_data  in  NUM_REQ*DSC_WIDTH  descriptors; slice i belongs to requester i
req_ready  out  NUM_REQ  one-hot, 1-cycle descriptor-accept pulse
rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_data  out  READREG_NUMBER*32  status words; zero on timeout
rsp_timeout  out  1  qualifies rsp_valid: job timed out
engine_start  out  1  1-cycle launch pulse to the engine
engine_ready  in  1  engine can take a descriptor
engine_data  out  DSC_WIDTH  latched descriptor
complete_ready  in  1  engine has completion status
complete_accept  out  1  completion consume strobe
complete_data  in  READREG_NUMBER*32  engine status words
busy  out  1  state != IDLE
grant_id  out  3  index of the current or last granted requester

Behaviour:
- Reset occurs on a clk edge with rst_n=0 and applies in any state, including mid-job. Reset values:
  - state=IDLE; all outputs 0; engine_data=0; grant_id=NUM_REQ-1, so requester 0 wins first.
  - Timeout counter=0.
  - An in-flight engine job is abandoned. Its later complete_ready is ignored until a new job reaches WAIT.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning upward, with wrap, from grant_id+1.
  - In that cycle: req_ready[g]=1 (combinational, one-hot), engine_data<=req_data slice g, grant_id<=g. Next state START.
  - Requester g must not drop req_valid before req_ready.
- START:
  - engine_start=1 only when engine_ready=1; then go to WAIT and clear the counter.
  - Otherwise hold START with engine_start=0.
- WAIT:
  - Counter increments every cycle.
  - If complete_ready=1: complete_accept=1 combinationally in that same cycle. Register rsp_data<=complete_data and rsp_timeout<=0. Next state RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: rsp_data<=0, rsp_timeout<=1. Next state RESP.
  - If completion and timeout fall in the same cycle, completion wins.
  - complete_accept is 0 in every other state.
- RESP:
  - rsp_valid[grant_id]=1; all other bits 0. rsp_data and rsp_timeout are held stable.
  - When rsp_ready[grant_id]=1: go to IDLE and drop rsp_valid next cycle.
  - rsp_ready bits of other requesters are ignored.
- Latency: req_valid (IDLE) to engine_start is minimum 2 cycles (grant cycle, START cycle).
  - Completion to rsp_valid is 1 cycle.
  - rsp_ready to next possible grant is 1 cycle (back in IDLE).
- Fairness: after serving g, g has the lowest priority next.
  - With all requesters active, the grant order is 0,1,..,N-1,0,...
  - Wrap-around uses modulo NUM_REQ; indices >= NUM_REQ are never granted.
- req_valid changes while not in IDLE have no effect. New requests wait; there is no queueing beyond the held req_valid.
- Counter width is 32 bits and saturates at all-ones when the timeout is disabled.

Test Plan:
1. Single requester: req_valid=4'b0010, descriptor 0xA5.., engine_ready=1, complete_ready 10 cycles after engine_start with complete_data=0x1234 -> required:
   - req_ready=4'b0010 for 1 cycle; engine_start 1 cycle later with engine_data=0xA5..
   - complete_accept pulses with complete_ready; rsp_valid=4'b0010 with rsp_data=0x1234, rsp_timeout=0.
2. Round-robin: req_valid=4'b1111 held, each job completes instantly -> grant order 0,1,2,3,0. Then req_valid=4'b1001 after serving 3 -> next grant is 0.
3. Engine back-pressure: engine_ready=0 for 5 cycles after grant -> engine_start stays 0, then pulses exactly once in the cycle engine_ready rises.
4. Timeout: TIMEOUT_CYCLES=16, no complete_ready -> after 16 WAIT cycles rsp_valid=1, rsp_timeout=1, rsp_data=0. Late complete_ready during RESP/IDLE must give no complete_accept.
5. Completion at the timeout cycle: complete_ready exactly at counter=15 -> rsp_timeout=0, rsp_data=complete_data, complete_accept=1.
6. Reset mid-WAIT and mid-RESP: rst_n=0 for 1 cycle -> next cycle busy=0, rsp_valid=0, engine_start=0, grant_id=NUM_REQ-1. Next request from requester 0 is granted first.
